// File: rtl/multdiv_stall_ctrl_if.sv
// Pipeline <-> multdiv sequencer bundle: D/X operands, multdiv handshake and X/M override.
// The slave side is the stall controller; the master side is the surrounding pipeline.
interface multdiv_stall_ctrl_if;
    logic        dx_is_mult;
    logic        dx_is_div;
    logic [4:0]  dx_rd;
    logic [31:0] dx_a;
    logic [31:0] dx_b;
    logic [31:0] md_result;
    logic        md_ready;
    logic        md_exception;
    logic [31:0] md_op_a;
    logic [31:0] md_op_b;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic        stall;
    logic        xm_override;
    logic [31:0] xm_data;
    logic [4:0]  xm_rd;

    modport slave (
        input  dx_is_mult, dx_is_div, dx_rd, dx_a, dx_b, md_result, md_ready, md_exception,
        output md_op_a, md_op_b, ctrl_mult, ctrl_div, stall, xm_override, xm_data, xm_rd
    );
    modport master (
        output dx_is_mult, dx_is_div, dx_rd, dx_a, dx_b, md_result, md_ready, md_exception,
        input  md_op_a, md_op_b, ctrl_mult, ctrl_div, stall, xm_override, xm_data, xm_rd
    );
endinterface

// File: rtl/multdiv_stall_ctrl.sv
// Sequences one multiply/divide at a time: freezes the front of the pipeline while the
// iterative unit runs, then injects the result (or an rstatus code to $r30) into X/M.
module multdiv_stall_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7,
    parameter int MUL_ERR = 4,
    parameter int DIV_ERR = 5
) (
    input  logic                clock,
    input  logic                reset,
    multdiv_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             is_mult_q;
    logic [4:0]       rd_q;
    logic             stall_q;
    logic             detect;
    logic             timed_out;

    assign detect    = bus.dx_is_mult | bus.dx_is_div;
    assign timed_out = (count == CNT_W'(TIMEOUT - 1));

    // The detect cycle must stall before the FSM has registered anything, so that term
    // is combinational; it is gated by reset so every output reads 0 while reset is held.
    assign bus.stall = stall_q | (reset & (state == IDLE) & detect);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            count           <= '0;
            is_mult_q       <= 1'b0;
            rd_q            <= '0;
            stall_q         <= 1'b0;
            bus.ctrl_mult   <= 1'b0;
            bus.ctrl_div    <= 1'b0;
            bus.md_op_a     <= '0;
            bus.md_op_b     <= '0;
            bus.xm_override <= 1'b0;
            bus.xm_data     <= '0;
            bus.xm_rd       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (detect) begin
                        state         <= START;
                        is_mult_q     <= bus.dx_is_mult;
                        rd_q          <= bus.dx_rd;
                        bus.md_op_a   <= bus.dx_a;
                        bus.md_op_b   <= bus.dx_b;
                        bus.ctrl_mult <= bus.dx_is_mult;
                        bus.ctrl_div  <= ~bus.dx_is_mult;
                        stall_q       <= 1'b1;
                    end
                end
                START: begin
                    state         <= BUSY;
                    count         <= '0;
                    bus.ctrl_mult <= 1'b0;
                    bus.ctrl_div  <= 1'b0;
                end
                BUSY: begin
                    if (count != '1)
                        count <= count + 1'b1;
                    // A ready arriving on the timeout cycle is still a normal completion.
                    if (bus.md_ready || timed_out) begin
                        state           <= DONE;
                        stall_q         <= 1'b0;
                        bus.xm_override <= 1'b1;
                        if (bus.md_ready && !bus.md_exception) begin
                            bus.xm_data <= bus.md_result;
                            bus.xm_rd   <= rd_q;
                        end else begin
                            bus.xm_data <= is_mult_q ? 32'(MUL_ERR) : 32'(DIV_ERR);
                            bus.xm_rd   <= 5'd30;
                        end
                    end
                end
                DONE: begin
                    state           <= IDLE;
                    bus.xm_override <= 1'b0;
                    bus.xm_data     <= '0;
                    bus.xm_rd       <= '0;
                    bus.md_op_a     <= '0;
                    bus.md_op_b     <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_stall_ctrl.sv
// Self-checking bench for multdiv_stall_ctrl: directed op table, corner sequences and a
// randomized run against a cycle-offset transaction model.
module tb_multdiv_stall_ctrl;
    localparam int TIMEOUT = 64;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    multdiv_stall_ctrl_if bus ();

    multdiv_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(7), .MUL_ERR(4), .DIV_ERR(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          m;
        bit          d;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          rdy_after;   // BUSY cycle index carrying md_ready; 0 = never
        bit          exc;
        logic [31:0] res;
        int          exp_stall;
        int          exp_cm;
        int          exp_cd;
        logic [31:0] exp_data;
        logic [4:0]  exp_rd;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.dx_is_mult   = 1'b0;
        bus.dx_is_div    = 1'b0;
        bus.dx_rd        = '0;
        bus.dx_a         = '0;
        bus.dx_b         = '0;
        bus.md_result    = '0;
        bus.md_ready     = 1'b0;
        bus.md_exception = 1'b0;
    endtask

    // Holds the op in D/X through DONE (as a frozen pipeline would) and drops it afterwards.
    task automatic run_op(input vec_t v, input int idx);
        int          st = 0;
        int          cm = 0;
        int          cd = 0;
        bit          done = 1'b0;
        logic [31:0] ga = '0;
        logic [31:0] gb = '0;
        bus.dx_is_mult = v.m;
        bus.dx_is_div  = v.d;
        bus.dx_a       = v.a;
        bus.dx_b       = v.b;
        bus.dx_rd      = v.rd;
        for (int c = 0; c < 200 && !done; c++) begin
            bus.md_ready     = (v.rdy_after > 0) && (c - 1 == v.rdy_after);
            bus.md_exception = bus.md_ready & v.exc;
            bus.md_result    = bus.md_ready ? v.res : 32'hffff_ffff;
            @(negedge clock);
            st += int'(bus.stall);
            cm += int'(bus.ctrl_mult);
            cd += int'(bus.ctrl_div);
            if (c == 1) begin
                ga = bus.md_op_a;
                gb = bus.md_op_b;
            end
            if (bus.xm_override) begin
                done = 1'b1;
                chk($sformatf("v%0d_xm_data", idx), bus.xm_data, v.exp_data);
                chk($sformatf("v%0d_xm_rd", idx), 32'(bus.xm_rd), 32'(v.exp_rd));
                chk($sformatf("v%0d_done_op_a", idx), bus.md_op_a, v.a);
            end
            @(posedge clock);
            #1;
        end
        clear_inputs();
        chk($sformatf("v%0d_done_seen", idx), 32'(done), 32'd1);
        chk($sformatf("v%0d_stall_cycles", idx), 32'(st), 32'(v.exp_stall));
        chk($sformatf("v%0d_mult_pulses", idx), 32'(cm), 32'(v.exp_cm));
        chk($sformatf("v%0d_div_pulses", idx), 32'(cd), 32'(v.exp_cd));
        chk($sformatf("v%0d_op_a", idx), ga, v.a);
        chk($sformatf("v%0d_op_b", idx), gb, v.b);
    endtask

    task automatic chk_quiet(input string nm);
        chk(nm, {28'd0, bus.stall, bus.ctrl_mult, bus.ctrl_div, bus.xm_override}, 32'd0);
    endtask

    // Random-phase model state: k = cycles since detection (-1 when no op in flight).
    int          k;
    bit          fin, fexc, cap_m;
    logic [31:0] cap_a, cap_b, fres;
    logic [4:0]  cap_rd;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        m  d  a            b        rd     rdy exc res          stall cm cd data         rd
        vecs[0] = '{1, 0, 32'd7,       32'd6,   5'd9,  32, 0, 32'd42,       34, 1, 0, 32'd42,       5'd9};
        vecs[1] = '{0, 1, 32'd9,       32'd0,   5'd12, 20, 1, 32'hdead,     22, 0, 1, 32'd5,        5'd30};
        vecs[2] = '{1, 0, 32'd3,       32'd11,  5'd3,  0,  0, 32'd0,        66, 1, 0, 32'd4,        5'd30};
        vecs[3] = '{1, 1, 32'd10,      32'd10,  5'd7,  5,  0, 32'd100,      7,  1, 0, 32'd100,      5'd7};
        vecs[4] = '{0, 1, 32'd6,       32'd2,   5'd0,  1,  0, 32'd3,        3,  0, 1, 32'd3,        5'd0};
        vecs[5] = '{1, 0, 32'h1234,    32'd1,   5'd31, 64, 0, 32'h1234,     66, 1, 0, 32'h1234,     5'd31};
        vecs[6] = '{0, 1, 32'd100,     32'd7,   5'd4,  0,  0, 32'd0,        66, 0, 1, 32'd5,        5'd30};
        vecs[7] = '{1, 0, 32'hffff_0000, 32'd2, 5'd8,  10, 1, 32'd0,        12, 1, 0, 32'd4,        5'd30};

        // Reset state, with a MUL already presented in D/X.
        clear_inputs();
        bus.dx_is_mult = 1'b1;
        #3;
        chk_quiet("reset_ctrl_bits");
        chk("reset_xm_data", bus.xm_data, 32'd0);
        chk("reset_op_a", bus.md_op_a, 32'd0);
        clear_inputs();
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        chk_quiet("idle_after_reset");
        @(posedge clock);
        #1;

        foreach (vecs[i]) run_op(vecs[i], i);
        @(negedge clock);
        chk_quiet("idle_after_table");
        @(posedge clock);
        #1;

        // Back-to-back MULs: the second is re-detected in the IDLE cycle after DONE.
        run_op(vecs[0], 10);
        run_op(vecs[7], 11);

        // Reset during BUSY: outputs clear at once, nothing fires afterwards.
        bus.dx_is_mult = 1'b1;
        bus.dx_a       = 32'd3;
        bus.dx_b       = 32'd4;
        bus.dx_rd      = 5'd5;
        repeat (12) begin
            @(posedge clock);
            #1;
        end
        chk("busy_stall_before_reset", 32'(bus.stall), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_quiet("midbusy_reset_ctrl_bits");
        chk("midbusy_reset_op_a", bus.md_op_a, 32'd0);
        chk("midbusy_reset_xm_data", bus.xm_data, 32'd0);
        clear_inputs();
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bus.md_ready     = c[0];
            bus.md_exception = c[1];
            bus.md_result    = 32'd77;
            @(negedge clock);
            chk_quiet($sformatf("stray_ready_c%0d", c));
            @(posedge clock);
            #1;
        end
        clear_inputs();

        // Randomized run against the transaction model.
        k = -1;
        fin = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int          r;
            bit          e_stall, e_cm, e_cd, e_ov;
            logic [31:0] e_a, e_b, e_data;
            logic [4:0]  e_rd;
            r = int'($urandom_range(7));
            bus.dx_is_mult   = (r == 0) || (r == 2);
            bus.dx_is_div    = (r == 1) || (r == 2);
            bus.dx_a         = $urandom;
            bus.dx_b         = $urandom;
            bus.dx_rd        = 5'($urandom);
            bus.md_ready     = ($urandom_range(39) == 0);
            bus.md_exception = ($urandom_range(3) == 0);
            bus.md_result    = $urandom;
            @(negedge clock);

            if (k < 0 && (bus.dx_is_mult || bus.dx_is_div)) begin
                k      = 0;
                cap_m  = bus.dx_is_mult;
                cap_a  = bus.dx_a;
                cap_b  = bus.dx_b;
                cap_rd = bus.dx_rd;
            end
            {e_stall, e_cm, e_cd, e_ov} = 4'b0;
            e_a = '0; e_b = '0; e_data = '0; e_rd = '0;
            if (k == 0) begin
                e_stall = 1'b1;
            end else if (fin) begin
                e_ov   = 1'b1;
                e_a    = cap_a;
                e_b    = cap_b;
                e_data = fexc ? (cap_m ? 32'd4 : 32'd5) : fres;
                e_rd   = fexc ? 5'd30 : cap_rd;
            end else if (k >= 1) begin
                e_stall = 1'b1;
                e_a     = cap_a;
                e_b     = cap_b;
                e_cm    = (k == 1) && cap_m;
                e_cd    = (k == 1) && !cap_m;
            end
            chk($sformatf("rand%0d_ctrl", cyc),
                {28'd0, bus.stall, bus.ctrl_mult, bus.ctrl_div, bus.xm_override},
                {28'd0, e_stall, e_cm, e_cd, e_ov});
            chk($sformatf("rand%0d_ops", cyc), bus.md_op_a ^ {bus.md_op_b[15:0], bus.md_op_b[31:16]},
                e_a ^ {e_b[15:0], e_b[31:16]});
            chk($sformatf("rand%0d_xm", cyc), bus.xm_data ^ {27'd0, bus.xm_rd}, e_data ^ {27'd0, e_rd});

            if (fin) begin
                k   = -1;
                fin = 1'b0;
            end else if (k >= 0) begin
                if (k >= 2) begin
                    if (bus.md_ready) begin
                        fin  = 1'b1;
                        fexc = bus.md_exception;
                        fres = bus.md_result;
                    end else if (k - 1 == TIMEOUT) begin
                        fin  = 1'b1;
                        fexc = 1'b1;
                    end
                end
                k++;
            end
            @(posedge clock);
            #1;
        end
        clear_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
